// File: rtl/idu_top_pkg.sv
// Shared encodings for the instruction-decode stage: opcodes, field positions,
// ALU/mem/exception codes and the ID/EX payload type.
package idu_top_pkg;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   localparam int unsigned OP_MSB  = 31;
   localparam int unsigned OP_LSB  = 26;
   localparam int unsigned RA_MSB  = 25;
   localparam int unsigned RA_LSB  = 21;
   localparam int unsigned RB_MSB  = 20;
   localparam int unsigned RB_LSB  = 16;
   localparam int unsigned RC_MSB  = 15;
   localparam int unsigned RC_LSB  = 11;
   localparam int unsigned IMM_MSB = 15;
   localparam int unsigned IMM_LSB = 0;

   localparam logic [5:0] OP_ANDR  = 6'h00, OP_ANDI  = 6'h01;
   localparam logic [5:0] OP_ORR   = 6'h02, OP_ORI   = 6'h03;
   localparam logic [5:0] OP_XORR  = 6'h04, OP_XORI  = 6'h05;
   localparam logic [5:0] OP_ADDSR = 6'h06, OP_ADDSI = 6'h07;
   localparam logic [5:0] OP_ADDUR = 6'h08, OP_ADDUI = 6'h09;
   localparam logic [5:0] OP_SUBSR = 6'h0A, OP_SUBUR = 6'h0B;
   localparam logic [5:0] OP_SHRLR = 6'h0C, OP_SHRLI = 6'h0D;
   localparam logic [5:0] OP_SHLLR = 6'h0E, OP_SHLLI = 6'h0F;
   localparam logic [5:0] OP_BE    = 6'h10, OP_BNE   = 6'h11;
   localparam logic [5:0] OP_BSR   = 6'h12, OP_JMP   = 6'h13;
   localparam logic [5:0] OP_LDW   = 6'h14, OP_STW   = 6'h15;
   localparam logic [5:0] OP_TRAP  = 6'h16;

   typedef enum logic [3:0] {
      ALU_NOP  = 4'd0, ALU_AND  = 4'd1, ALU_OR   = 4'd2, ALU_XOR  = 4'd3,
      ALU_ADDS = 4'd4, ALU_ADDU = 4'd5, ALU_SUBS = 4'd6, ALU_SUBU = 4'd7,
      ALU_SHRL = 4'd8, ALU_SHLL = 4'd9
   } alu_op_t;

   typedef enum logic [1:0] {MEM_NOP = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} mem_op_t;

   typedef enum logic [1:0] {EXP_NONE = 2'd0, EXP_ILLEGAL = 2'd1, EXP_TRAP = 2'd2} exp_code_t;

   typedef struct packed {
      alu_op_t     alu_op;
      logic [31:0] in0;
      logic [31:0] in1;
      mem_op_t     mem_op;
      logic [31:0] wr_data;
      logic [4:0]  dst;
      logic        we_;
      exp_code_t   exp_code;
   } idex_t;

   function automatic logic [31:0] sext16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   function automatic alu_op_t alu_of(input logic [5:0] op);
      case (op)
         OP_ANDR,  OP_ANDI:  return ALU_AND;
         OP_ORR,   OP_ORI:   return ALU_OR;
         OP_XORR,  OP_XORI:  return ALU_XOR;
         OP_ADDSR, OP_ADDSI: return ALU_ADDS;
         OP_ADDUR, OP_ADDUI: return ALU_ADDU;
         OP_SUBSR:           return ALU_SUBS;
         OP_SUBUR:           return ALU_SUBU;
         OP_SHRLR, OP_SHRLI: return ALU_SHRL;
         OP_SHLLR, OP_SHLLI: return ALU_SHLL;
         default:            return ALU_NOP;
      endcase
   endfunction

endpackage

// File: rtl/idu_top_if.sv
// Fetch/register-file facing bundle of the decode stage: instruction in,
// GPR read ports, and the branch redirect back to fetch.
interface idu_top_if;
   logic [29:0] if_pc;
   logic [31:0] if_insn;
   logic        if_en;
   logic [4:0]  gpr_rd_addr_0;
   logic [4:0]  gpr_rd_addr_1;
   logic [31:0] gpr_rd_data_0;
   logic [31:0] gpr_rd_data_1;
   logic        br_taken;
   logic [29:0] br_addr;

   modport master (
      output if_pc, if_insn, if_en, gpr_rd_data_0, gpr_rd_data_1,
      input  gpr_rd_addr_0, gpr_rd_addr_1, br_taken, br_addr
   );

   modport slave (
      input  if_pc, if_insn, if_en, gpr_rd_data_0, gpr_rd_data_1,
      output gpr_rd_addr_0, gpr_rd_addr_1, br_taken, br_addr
   );
endinterface

// File: rtl/idu_decoder.sv
// Combinational decode, operand forwarding, branch resolution and load-use
// detection. IDU_FWD_EN selects EX/MEM forwarding; otherwise GPR-only operands.
module idu_decoder
   import idu_top_pkg::*;
#(
   parameter int unsigned DST_LINK = 31
) (
   input  logic [29:0] if_pc,
   input  logic [31:0] if_insn,
   input  logic        if_en,
   input  logic [31:0] gpr_rd_data_0,
   input  logic [31:0] gpr_rd_data_1,
   input  logic        ex_en,
   input  logic        ex_gpr_we_,
   input  logic [4:0]  ex_dst_addr,
   input  logic [1:0]  ex_mem_op,
   input  logic [31:0] ex_fwd_data,
   input  logic        mem_en,
   input  logic        mem_gpr_we_,
   input  logic [4:0]  mem_dst_addr,
   input  logic [31:0] mem_fwd_data,
   output idex_t       dec,
   output logic        br_taken,
   output logic [29:0] br_addr,
   output logic        ld_hazard
);

   logic [5:0]  w_op;
   logic [4:0]  w_ra, w_rb, w_rc;
   logic [15:0] w_imm;
   logic [31:0] w_src0, w_src1;
   logic        w_use_ra, w_use_rb, w_cond;
   logic [29:0] w_target;
   logic        w_ex_wr, w_mem_wr, w_hit_ex, w_hit_mem;

   assign w_op  = if_insn[OP_MSB:OP_LSB];
   assign w_ra  = if_insn[RA_MSB:RA_LSB];
   assign w_rb  = if_insn[RB_MSB:RB_LSB];
   assign w_rc  = if_insn[RC_MSB:RC_LSB];
   assign w_imm = if_insn[IMM_MSB:IMM_LSB];

   assign w_ex_wr  = ex_en  && (ex_gpr_we_  == ENABLE_);
   assign w_mem_wr = mem_en && (mem_gpr_we_ == ENABLE_);

`ifdef IDU_FWD_EN
   always_comb begin
      if (w_ex_wr && ex_dst_addr == w_ra)        w_src0 = ex_fwd_data;
      else if (w_mem_wr && mem_dst_addr == w_ra) w_src0 = mem_fwd_data;
      else                                       w_src0 = gpr_rd_data_0;
      if (w_ex_wr && ex_dst_addr == w_rb)        w_src1 = ex_fwd_data;
      else if (w_mem_wr && mem_dst_addr == w_rb) w_src1 = mem_fwd_data;
      else                                       w_src1 = gpr_rd_data_1;
   end
`else
   logic w_unused;
   assign w_src0   = gpr_rd_data_0;
   assign w_src1   = gpr_rd_data_1;
   assign w_unused = ^{ex_fwd_data, mem_fwd_data, ex_mem_op};
`endif

   always_comb begin
      dec = '{alu_op: ALU_NOP, in0: w_src0, in1: w_src1, mem_op: MEM_NOP,
              wr_data: '0, dst: '0, we_: DISABLE_, exp_code: EXP_NONE};
      w_use_ra = 1'b0;
      w_use_rb = 1'b0;
      w_cond   = 1'b0;
      w_target = if_pc + 30'(sext16(w_imm));
      case (w_op)
         OP_ANDR, OP_ORR, OP_XORR, OP_ADDSR, OP_ADDUR,
         OP_SUBSR, OP_SUBUR, OP_SHRLR, OP_SHLLR: begin
            dec.alu_op = alu_of(w_op);
            dec.dst    = w_rc;
            dec.we_    = ENABLE_;
            w_use_ra   = 1'b1;
            w_use_rb   = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI, OP_ADDSI, OP_ADDUI, OP_SHRLI, OP_SHLLI: begin
            dec.alu_op = alu_of(w_op);
            dec.in1    = (w_op == OP_ADDSI || w_op == OP_ADDUI) ? sext16(w_imm) : {16'h0, w_imm};
            dec.dst    = w_rb;
            dec.we_    = ENABLE_;
            w_use_ra   = 1'b1;
         end
         OP_BE, OP_BNE: begin
            w_use_ra = 1'b1;
            w_use_rb = 1'b1;
            w_cond   = (w_src0 == w_src1) ^ (w_op == OP_BNE);
         end
         OP_BSR: begin
            dec.alu_op = ALU_ADDU;
            dec.in0    = {if_pc, 2'b00};
            dec.in1    = '0;
            dec.dst    = 5'(DST_LINK);
            dec.we_    = ENABLE_;
            w_cond     = 1'b1;
         end
         OP_JMP: begin
            w_use_ra = 1'b1;
            w_cond   = 1'b1;
            w_target = w_src0[31:2];
         end
         OP_LDW, OP_STW: begin
            dec.alu_op = ALU_ADDU;
            dec.in1    = sext16(w_imm);
            w_use_ra   = 1'b1;
            if (w_op == OP_LDW) begin
               dec.mem_op = MEM_LOAD;
               dec.dst    = w_rb;
               dec.we_    = ENABLE_;
            end else begin
               dec.mem_op  = MEM_STORE;
               dec.wr_data = w_src1;
               w_use_rb    = 1'b1;
            end
         end
         OP_TRAP: dec.exp_code = EXP_TRAP;
         default: dec.exp_code = EXP_ILLEGAL;
      endcase
   end

   // Only sources the opcode actually reads can create a hazard.
   assign w_hit_ex  = (w_use_ra && ex_dst_addr == w_ra)  || (w_use_rb && ex_dst_addr == w_rb);
   assign w_hit_mem = (w_use_ra && mem_dst_addr == w_ra) || (w_use_rb && mem_dst_addr == w_rb);

`ifdef IDU_FWD_EN
   assign ld_hazard = if_en && w_ex_wr && (ex_mem_op == MEM_LOAD) && w_hit_ex;
`else
   assign ld_hazard = if_en && ((w_ex_wr && w_hit_ex) || (w_mem_wr && w_hit_mem));
`endif

   assign br_taken = if_en && !ld_hazard && w_cond;
   assign br_addr  = br_taken ? w_target : '0;

endmodule

// File: rtl/idu_top.sv
// Decode stage top: idu_decoder plus the ID/EX pipeline register with
// reset > flush > stall > load-use bubble priority. Optional macro: IDU_FWD_EN.
module idu_top
   import idu_top_pkg::*;
#(
   parameter int unsigned DST_LINK = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   idu_top_if.slave    fe,
   input  logic        ex_en,
   input  logic        ex_gpr_we_,
   input  logic [4:0]  ex_dst_addr,
   input  logic [1:0]  ex_mem_op,
   input  logic [31:0] ex_fwd_data,
   input  logic        mem_en,
   input  logic        mem_gpr_we_,
   input  logic [4:0]  mem_dst_addr,
   input  logic [31:0] mem_fwd_data,
   output logic        ld_hazard,
   output logic [29:0] id_pc,
   output logic        id_en,
   output logic [3:0]  id_alu_op,
   output logic [31:0] id_alu_in_0,
   output logic [31:0] id_alu_in_1,
   output logic [1:0]  id_mem_op,
   output logic [31:0] id_mem_wr_data,
   output logic [4:0]  id_dst_addr,
   output logic        id_gpr_we_,
   output logic [1:0]  id_exp_code
);

   localparam idex_t BUBBLE = '{alu_op: ALU_NOP, in0: '0, in1: '0, mem_op: MEM_NOP,
                                wr_data: '0, dst: '0, we_: DISABLE_, exp_code: EXP_NONE};

   idex_t       w_dec;
   logic        w_hz;
   logic [29:0] r_pc;
   logic        r_en;
   idex_t       r_idex;

   assign fe.gpr_rd_addr_0 = fe.if_insn[RA_MSB:RA_LSB];
   assign fe.gpr_rd_addr_1 = fe.if_insn[RB_MSB:RB_LSB];

   idu_decoder #(.DST_LINK(DST_LINK)) u_dec (
      .if_pc         (fe.if_pc),
      .if_insn       (fe.if_insn),
      .if_en         (fe.if_en),
      .gpr_rd_data_0 (fe.gpr_rd_data_0),
      .gpr_rd_data_1 (fe.gpr_rd_data_1),
      .ex_en         (ex_en),
      .ex_gpr_we_    (ex_gpr_we_),
      .ex_dst_addr   (ex_dst_addr),
      .ex_mem_op     (ex_mem_op),
      .ex_fwd_data   (ex_fwd_data),
      .mem_en        (mem_en),
      .mem_gpr_we_   (mem_gpr_we_),
      .mem_dst_addr  (mem_dst_addr),
      .mem_fwd_data  (mem_fwd_data),
      .dec           (w_dec),
      .br_taken      (fe.br_taken),
      .br_addr       (fe.br_addr),
      .ld_hazard     (w_hz)
   );

   assign ld_hazard = w_hz;

   // A stalled hazard holds; the bubble is only inserted once the stall drops.
   always_ff @(posedge clk) begin
      if (!reset || flush || (!stall && w_hz)) begin
         r_pc   <= '0;
         r_en   <= 1'b0;
         r_idex <= BUBBLE;
      end else if (!stall) begin
         r_pc   <= fe.if_pc;
         r_en   <= fe.if_en;
         r_idex <= fe.if_en ? w_dec : BUBBLE;
      end
   end

   assign id_pc          = r_pc;
   assign id_en          = r_en;
   assign id_alu_op      = r_idex.alu_op;
   assign id_alu_in_0    = r_idex.in0;
   assign id_alu_in_1    = r_idex.in1;
   assign id_mem_op      = r_idex.mem_op;
   assign id_mem_wr_data = r_idex.wr_data;
   assign id_dst_addr    = r_idex.dst;
   assign id_gpr_we_     = r_idex.we_;
   assign id_exp_code    = r_idex.exp_code;

endmodule

// File: tb/tb_idu_top.sv
// Self-checking bench for idu_top: directed scenarios plus randomized traffic
// against a behavioural decode-stage model.
`timescale 1ns/1ps
module tb_idu_top;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, stall, flush;
   logic        ex_en, ex_gpr_we_, mem_en, mem_gpr_we_;
   logic [4:0]  ex_dst_addr, mem_dst_addr;
   logic [1:0]  ex_mem_op;
   logic [31:0] ex_fwd_data, mem_fwd_data;
   logic        ld_hazard, id_en, id_gpr_we_;
   logic [29:0] id_pc;
   logic [3:0]  id_alu_op;
   logic [31:0] id_alu_in_0, id_alu_in_1, id_mem_wr_data;
   logic [1:0]  id_mem_op, id_exp_code;
   logic [4:0]  id_dst_addr;

   idu_top_if bus();

   idu_top #(.DST_LINK(31)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .fe(bus),
      .ex_en(ex_en), .ex_gpr_we_(ex_gpr_we_), .ex_dst_addr(ex_dst_addr),
      .ex_mem_op(ex_mem_op), .ex_fwd_data(ex_fwd_data),
      .mem_en(mem_en), .mem_gpr_we_(mem_gpr_we_), .mem_dst_addr(mem_dst_addr),
      .mem_fwd_data(mem_fwd_data), .ld_hazard(ld_hazard),
      .id_pc(id_pc), .id_en(id_en), .id_alu_op(id_alu_op),
      .id_alu_in_0(id_alu_in_0), .id_alu_in_1(id_alu_in_1),
      .id_mem_op(id_mem_op), .id_mem_wr_data(id_mem_wr_data),
      .id_dst_addr(id_dst_addr), .id_gpr_we_(id_gpr_we_), .id_exp_code(id_exp_code)
   );

   int unsigned n_pass = 0, n_total = 0;
   logic [31:0] gpr [32];

   // model: combinational decode result
   logic [3:0]  d_alu;
   logic [31:0] d_in0, d_in1, d_wd;
   logic [1:0]  d_mop, d_exc;
   logic [4:0]  d_dst;
   logic        d_we, d_opdef, d_wddef;
   logic        e_hz, e_taken;
   logic [29:0] e_addr;
   // model: ID/EX register
   logic [29:0] m_pc;
   logic        m_en, m_we, m_opdef, m_wddef;
   logic [3:0]  m_alu;
   logic [31:0] m_in0, m_in1, m_wd;
   logic [1:0]  m_mop, m_exc;
   logic [4:0]  m_dst;

   function automatic logic [31:0] fwd(input logic [4:0] r);
`ifdef IDU_FWD_EN
      if (ex_en && !ex_gpr_we_ && ex_dst_addr == r)    return ex_fwd_data;
      if (mem_en && !mem_gpr_we_ && mem_dst_addr == r) return mem_fwd_data;
`endif
      return gpr[r];
   endfunction

   task automatic apply();
      bus.gpr_rd_data_0 = gpr[bus.if_insn[25:21]];
      bus.gpr_rd_data_1 = gpr[bus.if_insn[20:16]];
   endtask

   task automatic model_comb();
      int alu_tab [16] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5, 6, 7, 8, 8, 9, 9};
      logic [5:0]  op;
      logic [4:0]  ra, rb, rc;
      logic [31:0] a, b, sx, zx;
      logic        ua, ub, cond, rd_ex, rd_mem;
      logic [29:0] tgt;
      op = bus.if_insn[31:26]; ra = bus.if_insn[25:21];
      rb = bus.if_insn[20:16]; rc = bus.if_insn[15:11];
      a  = fwd(ra); b = fwd(rb);
      sx = {{16{bus.if_insn[15]}}, bus.if_insn[15:0]};
      zx = {16'h0, bus.if_insn[15:0]};
      d_alu = 0; d_in0 = 0; d_in1 = 0; d_wd = 0; d_mop = 0; d_exc = 0; d_dst = 0;
      d_we = 1; d_opdef = 0; d_wddef = 0; ua = 0; ub = 0; cond = 0;
      tgt = 30'(32'(bus.if_pc) + sx);
      if (op < 6'h10) begin
         d_alu = 4'(alu_tab[op[3:0]]); d_in0 = a; d_we = 0; d_opdef = 1; ua = 1;
         if (op[0] && op != 6'h0B) begin
            d_dst = rb; d_in1 = (op == 6'h07 || op == 6'h09) ? sx : zx;
         end else begin
            d_dst = rc; d_in1 = b; ub = 1;
         end
      end else begin
         case (op)
            6'h10: begin ua = 1; ub = 1; cond = (a == b); end
            6'h11: begin ua = 1; ub = 1; cond = (a != b); end
            6'h12: begin cond = 1; d_alu = 5; d_in0 = {bus.if_pc, 2'b00}; d_in1 = 0;
                         d_dst = 31; d_we = 0; d_opdef = 1; end
            6'h13: begin ua = 1; cond = 1; tgt = a[31:2]; end
            6'h14: begin ua = 1; d_alu = 5; d_in0 = a; d_in1 = sx; d_mop = 1;
                         d_dst = rb; d_we = 0; d_opdef = 1; end
            6'h15: begin ua = 1; ub = 1; d_alu = 5; d_in0 = a; d_in1 = sx; d_mop = 2;
                         d_wd = b; d_opdef = 1; d_wddef = 1; end
            6'h16: d_exc = 2;
            default: d_exc = 1;
         endcase
      end
      rd_ex  = (ua && ra == ex_dst_addr)  || (ub && rb == ex_dst_addr);
      rd_mem = (ua && ra == mem_dst_addr) || (ub && rb == mem_dst_addr);
`ifdef IDU_FWD_EN
      e_hz = bus.if_en && ex_en && !ex_gpr_we_ && ex_mem_op == 2'd1 && rd_ex;
`else
      e_hz = bus.if_en && ((ex_en && !ex_gpr_we_ && rd_ex) || (mem_en && !mem_gpr_we_ && rd_mem));
`endif
      e_taken = bus.if_en && !e_hz && cond;
      e_addr  = e_taken ? tgt : 30'd0;
   endtask

   task automatic model_bubble(input logic [29:0] pc);
      m_pc = pc; m_en = 0; m_alu = 0; m_in0 = 0; m_in1 = 0; m_mop = 0; m_wd = 0;
      m_dst = 0; m_we = 1; m_exc = 0; m_opdef = 1; m_wddef = 1;
   endtask

   task automatic tick();
      model_comb();
      if (!reset || flush) model_bubble(30'd0);
      else if (!stall) begin
         if (e_hz) model_bubble(30'd0);
         else if (!bus.if_en) model_bubble(bus.if_pc);
         else begin
            m_pc = bus.if_pc; m_en = 1; m_alu = d_alu; m_in0 = d_in0; m_in1 = d_in1;
            m_mop = d_mop; m_wd = d_wd; m_dst = d_dst; m_we = d_we; m_exc = d_exc;
            m_opdef = d_opdef; m_wddef = d_wddef;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle();
      reset = 1; stall = 0; flush = 0;
      ex_en = 0; ex_gpr_we_ = 1; ex_dst_addr = 0; ex_mem_op = 0; ex_fwd_data = 0;
      mem_en = 0; mem_gpr_we_ = 1; mem_dst_addr = 0; mem_fwd_data = 0;
      for (int i = 0; i < 32; i++) gpr[i] = 32'(i * 3);
   endtask

   task automatic test_reset();
      idle(); reset = 0;
      bus.if_insn = {6'h09, 5'd1, 5'd2, 16'h1234}; bus.if_pc = 30'h55; bus.if_en = 1; apply();
      tick(); tick();
      n_total++;
      if ({id_pc, id_en, id_alu_op, id_alu_in_0, id_alu_in_1, id_mem_op, id_mem_wr_data,
           id_dst_addr, id_gpr_we_, id_exp_code} !== {30'd0, 1'b0, 4'd0, 64'd0, 2'd0, 32'd0, 5'd0, 1'b1, 2'd0})
         $display("FAIL reset_state: id_en=%b we_=%b pc=%h alu=%h dst=%h", id_en, id_gpr_we_, id_pc, id_alu_op, id_dst_addr);
      else n_pass++;
      reset = 1;
   endtask

   task automatic test_addui();
      idle();
      gpr[1] = 5;
      bus.if_insn = {6'h09, 5'd1, 5'd2, 16'hFFFF}; bus.if_pc = 30'h1234; bus.if_en = 1; apply();
      tick();
      n_total++;
      if ({id_alu_in_0, id_alu_in_1} !== {32'd5, 32'hFFFFFFFF})
         $display("FAIL addui_operands: got %h/%h expected 5/ffffffff", id_alu_in_0, id_alu_in_1);
      else n_pass++;
      n_total++;
      if ({id_en, id_alu_op, id_dst_addr, id_gpr_we_, id_pc} !== {1'b1, 4'd5, 5'd2, 1'b0, 30'h1234})
         $display("FAIL addui_ctl: en=%b alu=%0d dst=%0d we_=%b pc=%h", id_en, id_alu_op, id_dst_addr, id_gpr_we_, id_pc);
      else n_pass++;
   endtask

   task automatic test_branch();
      logic exp_hz, exp_tk;
      idle();
      bus.if_insn = {6'h11, 5'd3, 5'd4, 16'hFFF0}; bus.if_pc = 30'h100; bus.if_en = 1;
      ex_en = 1; ex_gpr_we_ = 0; ex_dst_addr = 3; ex_mem_op = 0; ex_fwd_data = 7;
      gpr[3] = 0; gpr[4] = 7; apply(); #1;
`ifdef IDU_FWD_EN
      exp_hz = 0; exp_tk = 1;
`else
      exp_hz = 1; exp_tk = 0;
`endif
      n_total++;
      if ({ld_hazard, bus.br_taken} !== {exp_hz, 1'b0})
         $display("FAIL bne_fwd_equal: hz=%b taken=%b expected hz=%b taken=0", ld_hazard, bus.br_taken, exp_hz);
      else n_pass++;
      gpr[4] = 8; apply(); #1;
      n_total++;
      if ({bus.br_taken, bus.br_addr} !== {exp_tk, exp_tk ? 30'h0F0 : 30'h0})
         $display("FAIL bne_fwd_differ: taken=%b addr=%h expected taken=%b", bus.br_taken, bus.br_addr, exp_tk);
      else n_pass++;
      ex_en = 0; gpr[3] = 7; gpr[4] = 7; apply(); #1;
      n_total++;
      if ({bus.br_taken, bus.br_addr} !== {1'b0, 30'h0})
         $display("FAIL bne_gpr_equal: taken=%b addr=%h expected 0/0", bus.br_taken, bus.br_addr);
      else n_pass++;
      gpr[4] = 8; apply(); #1;
      n_total++;
      if ({bus.br_taken, bus.br_addr} !== {1'b1, 30'h0F0})
         $display("FAIL bne_gpr_differ: taken=%b addr=%h expected 1/0f0", bus.br_taken, bus.br_addr);
      else n_pass++;
      bus.if_en = 0; apply(); #1;
      n_total++;
      if ({bus.br_taken, bus.br_addr} !== {1'b0, 30'h0})
         $display("FAIL bne_invalid: taken=%b addr=%h expected 0/0", bus.br_taken, bus.br_addr);
      else n_pass++;
   endtask

   task automatic test_load_use();
      idle();
      ex_en = 1; ex_gpr_we_ = 0; ex_dst_addr = 5; ex_mem_op = 1;
      bus.if_insn = {6'h08, 5'd5, 5'd1, 5'd6, 11'd0}; bus.if_pc = 30'h40; bus.if_en = 1; apply(); #1;
      n_total++;
      if (ld_hazard !== 1'b1) $display("FAIL load_use_hz: got %b expected 1", ld_hazard);
      else n_pass++;
      tick();
      n_total++;
      if ({id_en, id_gpr_we_} !== 2'b01) $display("FAIL load_use_bubble: en=%b we_=%b expected 0/1", id_en, id_gpr_we_);
      else n_pass++;
      ex_en = 0;
      bus.if_insn = {6'h09, 5'd1, 5'd2, 16'h0010}; apply();
      tick();
      ex_en = 1; stall = 1;
      bus.if_insn = {6'h08, 5'd5, 5'd1, 5'd6, 11'd0}; apply(); #1;
      n_total++;
      if (ld_hazard !== 1'b1) $display("FAIL stall_hz_kept: got %b expected 1", ld_hazard);
      else n_pass++;
      tick();
      n_total++;
      if ({id_en, id_alu_op, id_dst_addr, id_alu_in_1} !== {1'b1, 4'd5, 5'd2, 32'h10})
         $display("FAIL stall_hold: en=%b alu=%0d dst=%0d in1=%h expected 1/5/2/10", id_en, id_alu_op, id_dst_addr, id_alu_in_1);
      else n_pass++;
   endtask

   task automatic test_exceptions();
      idle();
      bus.if_insn = {6'h3F, 26'h2AAAAAA}; bus.if_pc = 30'h8; bus.if_en = 1; apply(); #1;
      n_total++;
      if (bus.br_taken !== 1'b0) $display("FAIL illegal_br: got %b expected 0", bus.br_taken);
      else n_pass++;
      tick();
      n_total++;
      if ({id_exp_code, id_gpr_we_, id_alu_op, id_mem_op} !== {2'd1, 1'b1, 4'd0, 2'd0})
         $display("FAIL illegal_reg: exp=%0d we_=%b alu=%0d mem=%0d expected 1/1/0/0", id_exp_code, id_gpr_we_, id_alu_op, id_mem_op);
      else n_pass++;
      bus.if_insn = {6'h16, 26'h0}; apply();
      tick();
      n_total++;
      if ({id_exp_code, id_gpr_we_} !== {2'd2, 1'b1})
         $display("FAIL trap_reg: exp=%0d we_=%b expected 2/1", id_exp_code, id_gpr_we_);
      else n_pass++;
   endtask

   task automatic test_flush_stall();
      idle();
      bus.if_insn = {6'h09, 5'd1, 5'd2, 16'h0001}; bus.if_pc = 30'h77; bus.if_en = 1; apply();
      tick();
      flush = 1; stall = 1;
      tick();
      n_total++;
      if ({id_en, id_gpr_we_, id_alu_op, id_pc} !== {1'b0, 1'b1, 4'd0, 30'd0})
         $display("FAIL flush_beats_stall: en=%b we_=%b alu=%0d pc=%h expected bubble", id_en, id_gpr_we_, id_alu_op, id_pc);
      else n_pass++;
   endtask

   task automatic test_raw_nofwd();
      logic exp_hz;
`ifdef IDU_FWD_EN
      exp_hz = 0;
`else
      exp_hz = 1;
`endif
      idle();
      ex_en = 1; ex_gpr_we_ = 0; ex_dst_addr = 3; ex_mem_op = 0;
      bus.if_insn = {6'h08, 5'd3, 5'd1, 5'd6, 11'd0}; bus.if_en = 1; apply(); #1;
      n_total++;
      if (ld_hazard !== exp_hz) $display("FAIL raw_ex_alu: got %b expected %b", ld_hazard, exp_hz);
      else n_pass++;
      ex_en = 0; mem_en = 1; mem_gpr_we_ = 0; mem_dst_addr = 1; #1;
      n_total++;
      if (ld_hazard !== exp_hz) $display("FAIL raw_mem_rb: got %b expected %b", ld_hazard, exp_hz);
      else n_pass++;
      bus.if_insn = {6'h09, 5'd3, 5'd1, 16'h0}; #1;
      n_total++;
      if (ld_hazard !== 1'b0) $display("FAIL raw_unused_rb: got %b expected 0", ld_hazard);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [5:0] op;
      idle();
      for (int i = 0; i < 400; i++) begin
         op = 6'($urandom_range(0, 23));
         if (op == 6'd23) op = 6'($urandom_range(23, 63));
         bus.if_insn = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 11'($urandom)};
         bus.if_pc = 30'($urandom); bus.if_en = ($urandom_range(0, 5) != 0);
         for (int r = 0; r < 8; r++) gpr[r] = $urandom_range(0, 1) ? 32'($urandom_range(0, 3)) : $urandom;
         ex_en = 1'($urandom); ex_gpr_we_ = 1'($urandom); ex_dst_addr = 5'($urandom_range(0, 7));
         ex_mem_op = 2'($urandom_range(0, 2)); ex_fwd_data = $urandom_range(0, 3);
         mem_en = 1'($urandom); mem_gpr_we_ = 1'($urandom); mem_dst_addr = 5'($urandom_range(0, 7));
         mem_fwd_data = $urandom_range(0, 3);
         stall = ($urandom_range(0, 9) == 0); flush = ($urandom_range(0, 14) == 0);
         reset = ($urandom_range(0, 49) != 0);
         apply(); #1;
         model_comb();
         n_total++;
         if ({bus.gpr_rd_addr_0, bus.gpr_rd_addr_1} !== {bus.if_insn[25:21], bus.if_insn[20:16]})
            $display("FAIL rnd_rdaddr[%0d]: got %0d/%0d", i, bus.gpr_rd_addr_0, bus.gpr_rd_addr_1);
         else n_pass++;
         n_total++;
         if ({ld_hazard, bus.br_taken, bus.br_addr} !== {e_hz, e_taken, e_addr})
            $display("FAIL rnd_comb[%0d]: hz/tk/addr got %b/%b/%h expected %b/%b/%h", i,
                     ld_hazard, bus.br_taken, bus.br_addr, e_hz, e_taken, e_addr);
         else n_pass++;
         tick();
         n_total++;
         if ({id_pc, id_en, id_alu_op, id_mem_op, id_dst_addr, id_gpr_we_, id_exp_code} !==
             {m_pc, m_en, m_alu, m_mop, m_dst, m_we, m_exc})
            $display("FAIL rnd_ctl[%0d]: got %h expected %h", i,
                     {id_pc, id_en, id_alu_op, id_mem_op, id_dst_addr, id_gpr_we_, id_exp_code},
                     {m_pc, m_en, m_alu, m_mop, m_dst, m_we, m_exc});
         else n_pass++;
         if (m_opdef) begin
            n_total++;
            if ({id_alu_in_0, id_alu_in_1} !== {m_in0, m_in1})
               $display("FAIL rnd_opnd[%0d]: got %h/%h expected %h/%h", i, id_alu_in_0, id_alu_in_1, m_in0, m_in1);
            else n_pass++;
         end
         if (m_wddef) begin
            n_total++;
            if (id_mem_wr_data !== m_wd)
               $display("FAIL rnd_wdata[%0d]: got %h expected %h", i, id_mem_wr_data, m_wd);
            else n_pass++;
         end
      end
   endtask

   initial begin
      idle();
      reset = 0;
      bus.if_insn = '0; bus.if_pc = '0; bus.if_en = 0; apply();
      model_bubble(30'd0);
      @(posedge clk); #1;
      test_reset();
      test_addui();
      test_branch();
      test_load_use();
      test_exceptions();
      test_flush_stall();
      test_raw_nofwd();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
